i2c_slave: RTL
==============

I2C_SLAVE -- requirements
Module: i2c_slave

Interface
REQ-001 Parameter SLV_ADDR, default 7'h42, 7-bit bus address this target responds to.
REQ-002 clk  input  1  system clock; all logic is clocked on its rising edge.
REQ-003 reset  input  1  reset, synchronous and active-high.
REQ-004 scl  input  1  I2C clock from the master; this block never drives it.
REQ-005 sda  inout  1  I2C data line; open-drain, driven only as 1'b0 or 1'bz.
REQ-006 tx_data  input  8  byte returned to the master on a read.
REQ-007 tx_req  output  1  one-clk pulse: tx_data must be valid before the next SCL falling edge.
REQ-008 rx_data  output  8  last byte written by the master.
REQ-009 rx_valid  output  1  one-clk pulse: rx_data has been updated.
REQ-010 start_tick  output  1  one-clk pulse on a START or repeated START condition.
REQ-011 stop_tick  output  1  one-clk pulse on a STOP condition.
REQ-012 busy  output  1  high from an address match until STOP, START or NACK release.

Function
REQ-013 SCL and SDA shall pass through a 2-FF synchronizer.
REQ-014 Edge detection shall use the synchronized signals plus one delay stage.
REQ-015 START shall be detected when synced SDA falls while synced SCL is high; STOP when synced SDA rises while synced SCL is high.
REQ-016 The FSM shall have the states idle, addr, addr_ack, wr_data, wr_ack, rd_data, rd_ack and wait_stop.
REQ-017 START from any state shall go to addr, clear the bit counter and pulse start_tick.
REQ-018 STOP from any state shall go to idle and pulse stop_tick.
REQ-019 START and STOP take priority over SCL edges detected in the same clk.
REQ-020 addr state: shift in 8 bits, MSB first, on SCL rising edges (7 address bits, then R/W).
REQ-021 On the 8th rising edge, if the address equals SLV_ADDR, go to addr_ack and set busy; otherwise go to wait_stop and leave SDA released.
REQ-022 addr_ack: pull SDA low from the SCL falling edge after bit 8 until the next SCL falling edge.
REQ-023 In addr_ack with R/W=0, the next state is wr_data.
REQ-024 In addr_ack with R/W=1, pulse tx_req on the SCL rising edge of the ACK bit, latch tx_data on the following falling edge, then go to rd_data.
REQ-025 wr_data: sample 8 bits on SCL rising edges; after the 8th, update rx_data and pulse rx_valid in the next clk, then go to wr_ack.
REQ-026 wr_ack: ACK the same way as REQ-022, then return to wr_data.
REQ-027 rd_data: drive SDA low when the current bit is 0, otherwise release it.
REQ-028 rd_data: change SDA only on SCL falling edges, MSB first; release SDA after the 8th bit's falling edge, then go to rd_ack.
REQ-029 rd_ack: sample SDA on the SCL rising edge.
REQ-030 In rd_ack, a 0 (ACK) shall pulse tx_req in the same clk, latch tx_data on the next falling edge and return to rd_data.
REQ-031 In rd_ack, a 1 (NACK) shall go to wait_stop, clear busy and keep SDA released.
REQ-032 wait_stop: ignore SCL edges; leave only on START or STOP.
REQ-033 The bit counter is 4 bits and shall be cleared on every byte/ACK boundary; it shall never wrap past 8.
REQ-034 No clock stretching: SCL is never driven.
REQ-035 A general-call address (7'h00) shall not match unless SLV_ADDR = 7'h00.

Reset
REQ-036 reset shall force: state idle; shift registers 0; rx_data 8'h00; rx_valid, tx_req, start_tick, stop_tick and busy 0; SDA driver released (z); synchronizer stages 1.
REQ-037 reset asserted mid-transfer shall release SDA in the clk after reset is sampled, and the bus transaction is abandoned.

Configuration
REQ-038 Macro I2C_SLAVE_GLITCH_FILTER_EN: when defined, each synchronized line passes through a 3-sample majority filter before edge detection, adding 2 clk of latency and rejecting pulses of 1 clk or less.
REQ-039 When I2C_SLAVE_GLITCH_FILTER_EN is undefined, there is no filter and the synchronizer outputs feed edge detection directly.

Verification
REQ-040 Write 0x84, 0x5A, STOP -> address ACK, rx_data=8'h5A with one rx_valid pulse, ACK driven, one stop_tick, busy=0.
REQ-041 Write 0xA0 (address mismatch) -> SDA never driven low, state wait_stop, no rx_valid, no tx_req.
REQ-042 Read 0x85 with tx_data=8'hC3 then 8'h3C, master ACK then NACK -> SDA shows C3 then 3C, exactly 2 tx_req pulses, SDA released after the NACK.
REQ-043 Write 0x84, 0x11, repeated START, 0x85, read 1 byte -> start_tick pulses twice, rx_data=8'h11, read byte = tx_data.
REQ-044 Reset asserted during bit 4 of a read byte -> SDA=z in the next clk, all outputs at reset values; a following 0x84 write is ACKed.
REQ-045 With the macro defined, a 1-clk SCL glitch during wr_data -> no extra bit shifted, rx_data still correct.

Source files
------------

// File: rtl/i2c_slave.sv
// i2c_slave: 7-bit addressed I2C target (write and read), no clock stretching.
// SCL is only observed. SDA is open-drain: it is driven to 1'b0 or left at 1'bz.
// Build option: define I2C_SLAVE_GLITCH_FILTER_EN to put a 3-sample majority
// filter on each synchronized line ahead of edge detection.

module i2c_slave #(
  parameter logic [6:0] SLV_ADDR = 7'h42
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl,
  inout  wire        sda,
  input  logic [7:0] tx_data,
  output logic       tx_req,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       start_tick,
  output logic       stop_tick,
  output logic       busy
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_ADDR, ST_ADDR_ACK, ST_WR_DATA,
    ST_WR_ACK, ST_RD_DATA, ST_RD_ACK, ST_WAIT_STOP
  } state_t;

  // ---------------- input synchronizers ----------------
  logic scl_s1_q, scl_s1_d, scl_s2_q, scl_s2_d;
  logic sda_s1_q, sda_s1_d, sda_s2_q, sda_s2_d;

  // Two-stage synchronizer next values
  always_comb begin
    scl_s1_d = scl;
    scl_s2_d = scl_s1_q;
    sda_s1_d = sda;
    sda_s2_d = sda_s1_q;
  end

  // Synchronizer flops, reset to the idle (high) bus level so no false edge follows reset
  always_ff @(posedge clk) begin
    if (reset) begin
      scl_s1_q <= 1'b1;
      scl_s2_q <= 1'b1;
      sda_s1_q <= 1'b1;
      sda_s2_q <= 1'b1;
    end else begin
      scl_s1_q <= scl_s1_d;
      scl_s2_q <= scl_s2_d;
      sda_s1_q <= sda_s1_d;
      sda_s2_q <= sda_s2_d;
    end
  end

  logic scl_f, sda_f;  // line values seen by edge detection

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
  logic scl_h1_q, scl_h1_d, scl_h2_q, scl_h2_d, scl_flt_q, scl_flt_d;
  logic sda_h1_q, sda_h1_d, sda_h2_q, sda_h2_d, sda_flt_q, sda_flt_d;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Majority of the newest three samples; a single-sample pulse never wins the vote
  always_comb begin
    scl_h1_d  = scl_s2_q;
    scl_h2_d  = scl_h1_q;
    scl_flt_d = maj3(scl_s2_q, scl_h1_q, scl_h2_q);
    sda_h1_d  = sda_s2_q;
    sda_h2_d  = sda_h1_q;
    sda_flt_d = maj3(sda_s2_q, sda_h1_q, sda_h2_q);
  end

  // Filter history and output flops
  always_ff @(posedge clk) begin
    if (reset) begin
      scl_h1_q  <= 1'b1;
      scl_h2_q  <= 1'b1;
      scl_flt_q <= 1'b1;
      sda_h1_q  <= 1'b1;
      sda_h2_q  <= 1'b1;
      sda_flt_q <= 1'b1;
    end else begin
      scl_h1_q  <= scl_h1_d;
      scl_h2_q  <= scl_h2_d;
      scl_flt_q <= scl_flt_d;
      sda_h1_q  <= sda_h1_d;
      sda_h2_q  <= sda_h2_d;
      sda_flt_q <= sda_flt_d;
    end
  end

  assign scl_f = scl_flt_q;
  assign sda_f = sda_flt_q;
`else
  assign scl_f = scl_s2_q;
  assign sda_f = sda_s2_q;
`endif

  // ---------------- edge / condition detection ----------------
  logic scl_dly_q, scl_dly_d, sda_dly_q, sda_dly_d;

  // One-sample delay used to find edges
  always_comb begin
    scl_dly_d = scl_f;
    sda_dly_d = sda_f;
  end

  // Delay stage flops
  always_ff @(posedge clk) begin
    if (reset) begin
      scl_dly_q <= 1'b1;
      sda_dly_q <= 1'b1;
    end else begin
      scl_dly_q <= scl_dly_d;
      sda_dly_q <= sda_dly_d;
    end
  end

  logic scl_rise, scl_fall, start_det, stop_det;
  assign scl_rise  = scl_f & ~scl_dly_q;
  assign scl_fall  = ~scl_f & scl_dly_q;
  assign start_det = scl_f & scl_dly_q & sda_dly_q & ~sda_f;
  assign stop_det  = scl_f & scl_dly_q & ~sda_dly_q & sda_f;

  // ---------------- protocol FSM ----------------
  state_t      state_q, state_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [6:0]  shift_q, shift_d;      // 7 bits suffice: the 8th bit is taken straight from SDA
  logic [7:0]  tx_shift_q, tx_shift_d;
  logic        rw_q, rw_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic        rx_valid_q, rx_valid_d;
  logic        tx_req_q, tx_req_d;
  logic        start_tick_q, start_tick_d;
  logic        stop_tick_q, stop_tick_d;
  logic        busy_q, busy_d;
  logic        sda_oe_q, sda_oe_d;    // 1 = pull SDA low

  // FSM state and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      bit_cnt_q    <= 4'd0;
      shift_q      <= 7'd0;
      tx_shift_q   <= 8'd0;
      rw_q         <= 1'b0;
      rx_data_q    <= 8'h00;
      rx_valid_q   <= 1'b0;
      tx_req_q     <= 1'b0;
      start_tick_q <= 1'b0;
      stop_tick_q  <= 1'b0;
      busy_q       <= 1'b0;
      sda_oe_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      tx_shift_q   <= tx_shift_d;
      rw_q         <= rw_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      tx_req_q     <= tx_req_d;
      start_tick_q <= start_tick_d;
      stop_tick_q  <= stop_tick_d;
      busy_q       <= busy_d;
      sda_oe_q     <= sda_oe_d;
    end
  end

  // Next-state and output logic; START/STOP override any SCL edge in the same clk.
  // In the ACK states bit_cnt is 0 before the ACK clock's rising edge and 1 after it.
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    tx_shift_d   = tx_shift_q;
    rw_d         = rw_q;
    rx_data_d    = rx_data_q;
    rx_valid_d   = 1'b0;
    tx_req_d     = 1'b0;
    start_tick_d = 1'b0;
    stop_tick_d  = 1'b0;
    busy_d       = busy_q;
    sda_oe_d     = sda_oe_q;

    if (start_det) begin
      state_d      = ST_ADDR;
      bit_cnt_d    = 4'd0;
      shift_d      = 7'd0;
      start_tick_d = 1'b1;
      busy_d       = 1'b0;
      sda_oe_d     = 1'b0;
    end else if (stop_det) begin
      state_d     = ST_IDLE;
      bit_cnt_d   = 4'd0;
      stop_tick_d = 1'b1;
      busy_d      = 1'b0;
      sda_oe_d    = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          sda_oe_d = 1'b0;
        end
        ST_ADDR, ST_WR_DATA: begin
          if (scl_rise) begin
            shift_d = {shift_q[5:0], sda_f};
            if (bit_cnt_q == 4'd7) begin
              bit_cnt_d = 4'd0;
              if (state_q == ST_ADDR) begin
                rw_d = sda_f;
                if (shift_q == SLV_ADDR) begin
                  state_d = ST_ADDR_ACK;
                  busy_d  = 1'b1;
                end else begin
                  state_d = ST_WAIT_STOP;
                end
              end else begin
                rx_data_d  = {shift_q, sda_f};
                rx_valid_d = 1'b1;
                state_d    = ST_WR_ACK;
              end
            end else begin
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end else begin
            shift_d = shift_q;
          end
        end
        ST_ADDR_ACK, ST_WR_ACK: begin
          if (scl_fall) begin
            if (bit_cnt_q == 4'd0) begin
              sda_oe_d = 1'b1;
            end else if (state_q == ST_ADDR_ACK && rw_q) begin
              bit_cnt_d  = 4'd0;
              tx_shift_d = tx_data;
              sda_oe_d   = ~tx_data[7];
              state_d    = ST_RD_DATA;
            end else begin
              bit_cnt_d = 4'd0;
              sda_oe_d  = 1'b0;
              state_d   = ST_WR_DATA;
            end
          end else if (scl_rise) begin
            bit_cnt_d = 4'd1;
            tx_req_d  = (state_q == ST_ADDR_ACK) && rw_q;
          end else begin
            bit_cnt_d = bit_cnt_q;
          end
        end
        ST_RD_DATA: begin
          if (scl_fall) begin
            if (bit_cnt_q >= 4'd8) begin
              bit_cnt_d = 4'd0;
              sda_oe_d  = 1'b0;
              state_d   = ST_RD_ACK;
            end else begin
              sda_oe_d = ~tx_shift_q[3'd7 - bit_cnt_q[2:0]];
            end
          end else if (scl_rise && bit_cnt_q < 4'd8) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else begin
            bit_cnt_d = bit_cnt_q;
          end
        end
        ST_RD_ACK: begin
          if (scl_rise) begin
            if (!sda_f) begin
              tx_req_d  = 1'b1;
              bit_cnt_d = 4'd1;
            end else begin
              bit_cnt_d = 4'd0;
              busy_d    = 1'b0;
              sda_oe_d  = 1'b0;
              state_d   = ST_WAIT_STOP;
            end
          end else if (scl_fall && bit_cnt_q == 4'd1) begin
            bit_cnt_d  = 4'd0;
            tx_shift_d = tx_data;
            sda_oe_d   = ~tx_data[7];
            state_d    = ST_RD_DATA;
          end else begin
            bit_cnt_d = bit_cnt_q;
          end
        end
        ST_WAIT_STOP: begin
          sda_oe_d = 1'b0;
        end
        default: begin
          state_d  = ST_IDLE;
          sda_oe_d = 1'b0;
        end
      endcase
    end
  end

  assign sda        = sda_oe_q ? 1'b0 : 1'bz;
  assign tx_req     = tx_req_q;
  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign start_tick = start_tick_q;
  assign stop_tick  = stop_tick_q;
  assign busy       = busy_q;

endmodule
